bram_row_reader: RTL and testbench
==================================

Name: bram_row_reader

Overview:
Read-side controller for a 2**ADDR_WIDTH-entry row buffer with combinational read data. On `start`, it waits for the buffer's row-full flag. It then sweeps the read address 0..DEPTH-1, asserting the read enable only in cycles where it captures a word. Captured words go to a downstream LSTM datapath consumer over a registered valid/ready stream with a last flag.

Parameters:
- DATA_WIDTH, 32, width of one row word.
- ADDR_WIDTH, 4, row address width; DEPTH = 2**ADDR_WIDTH words per row.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to read one full row; ignored unless in IDLE.
- row_full  input  1  buffer's row-written flag; high while the row is readable.
- rd_en  output  1  buffer read enable; each high cycle consumes one word at the buffer.
- rd_addr  output  ADDR_WIDTH  buffer read address.
- rd_data  input  DATA_WIDTH  buffer read data, combinational from rd_addr, valid while rd_en and row_full are high.
- m_valid  output  1  output word valid.
- m_data  output  DATA_WIDTH  output word.
- m_last  output  1  high with m_valid on word DEPTH-1.
- m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.
- busy  output  1  high in every state except IDLE.
- row_done  output  1  one-cycle pulse after the last word is accepted.
- err  output  1  sticky; row_full fell while words remained; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; output register empty.
- States and transitions:
  - IDLE: start=1 goes to ARM and clears err.
  - ARM: waits for row_full=1, then goes to READ. There is no timeout.
  - READ: the capture condition is `cap = row_full & (!m_valid | m_ready)`.
    - rd_en = cap (combinational from state, row_full, m_valid, m_ready); rd_addr = index.
    - On cap: m_data <= rd_data; m_valid <= 1; m_last <= (index == DEPTH-1); index increments.
    - After capturing index DEPTH-1, go to DRAIN; index wraps to 0.
    - Without cap, m_valid stays 1 while m_ready=0 (holding the word) and drops to 0 when the held word is accepted. rd_en stays 0.
  - DRAIN: rd_en=0. When m_valid & m_ready & m_last: m_valid <= 0, pulse row_done for 1 cycle, go to IDLE.
- Latency:
  - start to first rd_en: 1 cycle minimum if row_full is already high.
  - Capture to m_valid: 1 cycle.
  - Full throughput with m_ready tied high: DEPTH words in DEPTH consecutive cycles, row_done in cycle DEPTH+2 after entering READ.
- Backpressure: rd_en is never high while a held word is unaccepted; no word is lost or duplicated. This holds the buffer's internal read counter in lockstep with index.
- row_full low during READ: cap=0, err <= 1, return to IDLE. m_valid drops once the held word is accepted. row_done does not pulse.
- start while busy: ignored; no error.
- rst_n asserted mid-row: immediate return to reset values. The buffer must be reset too, since its read counter is not re-synchronised.

Optional Feature:
Macro BRAM_ROW_READER_CHKSUM_EN.
- Defined: adds output `row_chksum` [DATA_WIDTH-1:0].
  - It is a running XOR of every captured word, cleared on the accepted start.
  - It is valid and stable from the row_done pulse until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lstm_bram_pkg holds:
  - the state encoding localparams (IDLE=0, ARM=1, READ=2, DRAIN=3);
  - the DEPTH = 2**ADDR_WIDTH derivation;
  - a shared constant for the default row widths, used by both writer and reader sides.
- One natural sub-module: stream_out_reg, the one-entry output register with valid/ready/last. It is reusable for other LSTM stream stages.

Test Plan:
- DATA_WIDTH=32, ADDR_WIDTH=4; buffer preloaded with word i = 0xA000_0000+i; row_full=1; m_ready=1; start pulse:
  - rd_addr sweeps 0..15 over 16 consecutive cycles.
  - m_data = 0xA0000000..0xA000000F in order; m_last only on 0xA000000F.
  - row_done pulses once; rd_en is high on exactly 16 cycles.
- Same row with m_ready toggling 1,0,0,1 repeating:
  - all 16 words are delivered exactly once, in order.
  - rd_en count = 16; rd_en is never high while m_valid=1 & m_ready=0.
- start with row_full=0 for 10 cycles, then 1:
  - busy=1 and rd_en=0 during the 10-cycle wait.
  - first rd_en occurs in the cycle row_full rises.
- row_full dropped after word 5 is accepted:
  - err=1, return to IDLE, no row_done.
  - the next start clears err.
- start re-pulsed during READ: ignored, and the sequence completes unchanged. rst_n pulsed at word 8: all outputs 0 the same cycle.
- With BRAM_ROW_READER_CHKSUM_EN defined, the first scenario gives row_chksum = 0x00000000, since the XOR of 0xA0000000..0xA000000F is 0 (even count of 0xA0000000 and 0^1^…^15 = 0).
- Words 0x1,0x2,0x4 followed by 13 zero words give row_chksum = 0x00000007.

Source files
------------

// File: rtl/lstm_bram_pkg.sv
// Shared definitions for the LSTM row-buffer writer and reader sides.
//   - default row geometry (word width, address width)
//   - reader FSM state encoding
//   - row depth derivation from the address width
package lstm_bram_pkg;

    // Default row geometry shared by the writer and reader.
    localparam int unsigned ROW_DATA_WIDTH = 32;
    localparam int unsigned ROW_ADDR_WIDTH = 4;

    // Reader state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARM   = ST_ARM,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN
    } row_state_e;

    // Number of words in a row for a given address width.
    function automatic int unsigned row_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry registered valid/ready output stage with a last flag.
// A load always wins; otherwise an accepted word empties the register.
// The owner must only load when the register is empty or being accepted.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                capture load_data/load_last this cycle
//   load_data/load_last word and last flag to capture
//   m_ready             downstream accept
//   m_valid/m_data/m_last registered stream outputs
module stream_out_reg
    import lstm_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ROW_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    // Output register: load has priority over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/bram_row_reader.sv
// Read-side controller for a row buffer with combinational read data.
// On start it waits for row_full, sweeps rd_addr 0..DEPTH-1 and forwards
// each captured word over a registered valid/ready/last stream.
// rd_en is only raised in cycles where a word is captured, so the buffer's
// internal read counter stays in lockstep with the sweep index.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request one row (ignored unless idle)
//   row_full          buffer row readable
//   rd_en, rd_addr    buffer read strobe/address (combinational)
//   rd_data           buffer read data (combinational from rd_addr)
//   m_valid/m_data/m_last/m_ready  output stream
//   busy              not idle
//   row_done          one-cycle pulse after the last word is accepted
//   err               sticky: row_full fell mid-row; cleared by start
//   row_chksum        XOR of the row's words (only with BRAM_ROW_READER_CHKSUM_EN)
module bram_row_reader
    import lstm_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ROW_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ROW_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  row_full,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  row_done,
`ifdef BRAM_ROW_READER_CHKSUM_EN
    output logic [DATA_WIDTH-1:0] row_chksum,
`endif
    output logic                  err
);

    localparam int unsigned DEPTH = row_depth(ADDR_WIDTH);

    row_state_e            state;
    row_state_e            state_d;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] index_d;
    logic                  err_d;
    logic                  row_done_d;
    logic                  cap;
    logic                  slot_free;
    logic                  index_is_last;

    // Output slot can take a new word if empty or being accepted now.
    assign slot_free     = !m_valid || m_ready;
    assign index_is_last = (index == ADDR_WIDTH'(DEPTH - 1));

    assign rd_en   = cap;
    assign rd_addr = index;
    assign busy    = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            index    <= '0;
            err      <= 1'b0;
            row_done <= 1'b0;
        end else begin
            state    <= state_d;
            index    <= index_d;
            err      <= err_d;
            row_done <= row_done_d;
        end
    end

    // Next-state and capture decode. ARM captures word 0 in the same cycle
    // row_full is seen so the first read lines up with row_full rising.
    always_comb begin
        state_d    = state;
        index_d    = index;
        err_d      = err;
        row_done_d = 1'b0;
        cap        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    err_d   = 1'b0;
                    index_d = '0;
                end
            end
            S_ARM: begin
                if (row_full) begin
                    state_d = S_READ;
                    cap     = slot_free;
                end
            end
            S_READ: begin
                if (!row_full) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    index_d = '0;
                end else begin
                    cap = slot_free;
                end
            end
            S_DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    row_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Index wraps to 0 after the last word.
        if (cap) begin
            index_d = index + ADDR_WIDTH'(1);
            if (index_is_last) begin
                state_d = S_DRAIN;
            end
        end
    end

    stream_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cap),
        .load_data(rd_data),
        .load_last(index_is_last),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last)
    );

`ifdef BRAM_ROW_READER_CHKSUM_EN
    logic [DATA_WIDTH-1:0] chksum_d;

    // Running XOR of captured words, restarted by an accepted start.
    always_comb begin
        chksum_d = row_chksum;
        if (state == S_IDLE && start) begin
            chksum_d = '0;
        end
        if (cap) begin
            chksum_d = row_chksum ^ rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_chksum <= '0;
        end else begin
            row_chksum <= chksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_bram_row_reader.sv
// Self-checking bench for bram_row_reader (DATA_WIDTH=32, ADDR_WIDTH=4).
// A behavioural row buffer feeds rd_data; the reference model expects word i
// of the row to be delivered i-th, exactly once, with last on word DEPTH-1.
module tb_bram_row_reader;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          row_full;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          row_done;
    logic          err;
`ifdef BRAM_ROW_READER_CHKSUM_EN
    logic [DW-1:0] row_chksum;
`endif

    logic [DW-1:0] mem [DEPTH];
    assign rd_data = mem[rd_addr];

    bram_row_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .row_full (row_full),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .row_done (row_done),
`ifdef BRAM_ROW_READER_CHKSUM_EN
        .row_chksum(row_chksum),
`endif
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model / scoreboard state.
    logic [DW-1:0] exp_q [$];
    int acc_idx;
    int n_rden;
    int n_done;
    int buf_cnt;
    int viol;
    int cyc = 0;
    int first_rd;
    int last_rd;
    logic s_rd_en, s_busy, s_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_xor();
        logic [DW-1:0] x = '0;
        for (int i = 0; i < DEPTH; i++) x ^= mem[i];
        return x;
    endfunction

    function automatic bit rdy_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic begin_row();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        acc_idx  = 0;
        n_rden   = 0;
        n_done   = 0;
        buf_cnt  = 0;
        viol     = 0;
        first_rd = -1;
        last_rd  = -1;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later.
    task automatic cycle(input bit rdy, input bit rf, input bit st);
        logic [DW-1:0] w;
        @(negedge clk);
        m_ready  = rdy;
        row_full = rf;
        start    = st;
        #1;
        cyc++;
        s_rd_en = rd_en;
        s_busy  = busy;
        s_err   = err;
        if (rd_en) begin
            check("rd_addr_lockstep", 64'(rd_addr), 64'(buf_cnt));
            buf_cnt++;
            n_rden++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (m_valid && !m_ready) viol++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(m_data), 64'hDEAD);
            end else begin
                w = exp_q.pop_front();
                check("m_data", 64'(m_data), 64'(w));
                check("m_last", 64'(m_last), 64'(acc_idx == DEPTH - 1));
            end
            acc_idx++;
        end
        if (row_done) n_done++;
    endtask

    task automatic finish_row(input int mode, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            cycle(rdy_for(mode, k), 1'b1, 1'b0);
            k++;
        end
        check("done_in_budget", 64'(n_done != 0), 64'd1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        check("row_done_once", 64'(n_done), 64'd1);
        check("rd_en_count", 64'(n_rden), 64'(DEPTH));
        check("words_delivered", 64'(acc_idx), 64'(DEPTH));
        check("no_rd_under_stall", 64'(viol), 64'd0);
        check("idle_after_row", 64'(s_busy), 64'd0);
`ifdef BRAM_ROW_READER_CHKSUM_EN
        check("row_chksum", 64'(row_chksum), 64'(model_xor()));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        start    = 1'b0;
        row_full = 1'b0;
        m_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + DW'(i);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_row_done", 64'(row_done), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full throughput row.
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        finish_row(0, 60);
        check("sweep_consecutive", 64'(last_rd - first_rd), 64'(DEPTH - 1));
`ifdef BRAM_ROW_READER_CHKSUM_EN
        check("chksum_a000_row", 64'(row_chksum), 64'd0);
`endif

        // Ready pattern 1,0,0,1.
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        finish_row(1, 120);

        // row_full low for 10 cycles after start.
        begin_row();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("wait_busy", 64'(s_busy), 64'd1);
            check("wait_no_rd_en", 64'(s_rd_en), 64'd0);
        end
        cycle(1'b1, 1'b1, 1'b0);
        check("rd_en_on_row_full_rise", 64'(s_rd_en), 64'd1);
        finish_row(0, 60);

        // row_full drops after word 5 accepted.
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        k = 0;
        while (acc_idx < 6 && k < 40) begin
            cycle(1'b1, 1'b1, 1'b0);
            k++;
        end
        check("reach_word5", 64'(acc_idx >= 6), 64'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("err_set", 64'(s_err), 64'd1);
        check("err_idle", 64'(s_busy), 64'd0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("err_no_row_done", 64'(n_done), 64'd0);
        check("err_no_loss", 64'(acc_idx), 64'(n_rden));
        check("err_sticky", 64'(s_err), 64'd1);
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("err_cleared_by_start", 64'(s_err), 64'd0);
        finish_row(0, 60);

        // start re-pulsed mid-row is ignored.
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        finish_row(0, 60);
        check("restart_ignored_err", 64'(s_err), 64'd0);

        // Random data, random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            begin_row();
            cycle(1'b1, 1'b1, 1'b1);
            finish_row(2, 300);
        end

        // Sparse words 1,2,4 then zeros.
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = 32'h1;
        mem[1] = 32'h2;
        mem[2] = 32'h4;
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        finish_row(2, 300);
`ifdef BRAM_ROW_READER_CHKSUM_EN
        check("chksum_124", 64'(row_chksum), 64'h7);
`endif

        // Reset asserted mid-row at word 8.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + DW'(i);
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        k = 0;
        while (acc_idx < 8 && k < 40) begin
            cycle(1'b1, 1'b1, 1'b0);
            k++;
        end
        check("reach_word8", 64'(acc_idx >= 8), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        check("mid_rst_m_last", 64'(m_last), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_row_done", 64'(row_done), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean row after reset (buffer reset alongside).
        begin_row();
        cycle(1'b1, 1'b1, 1'b1);
        finish_row(0, 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
